// File: rtl/spi_master.sv
// rtl/spi_master.sv - parametrised SPI master: divided SCK, four CPOL/CPHA modes,
// MSB/LSB-first words and automatically managed active-low chip selects with optional hold.
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic              hold_cs_i,
  input  logic              cs_release_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sck_o,
  output logic              sdo_o,
  input  logic              sdi_i,
  output logic [NUM_CS-1:0] cs_n_o
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [WIDTH-1:0]   tx_sr, rx_sr, data_q;
  logic               cpha_q, lsb_q, hold_q;
  logic               tick, last_edge, leading, accept;

  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_edge = (edge_cnt == EDGE_W'(2 * WIDTH - 1));
  assign leading   = ~edge_cnt[0];
  assign accept    = start_i & ~busy_o;

  function automatic logic [NUM_CS-1:0] cs_pattern(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] p;
    for (int i = 0; i < NUM_CS; i++) p[i] = (32'(sel) != i);
    return p;
  endfunction

  function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   if (tick) state_n = XFER;
      XFER:    if (tick && last_edge) state_n = HOLD;
      HOLD:    if (tick) state_n = accept ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    done_o = 1'b0;
    busy_o = 1'b0;
    done_o = (state == HOLD) && tick;
    busy_o = (state != IDLE) && !done_o;
  end

  // The received word is visible in the done cycle itself, then held in data_q.
  assign data_o = done_o ? rx_sr : data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      data_q   <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
      sck_o    <= 1'b0;
      sdo_o    <= 1'b0;
      cs_n_o   <= '1;
    end else begin
      if (accept)              div_cnt <= '0;
      else if (state != IDLE)  div_cnt <= tick ? '0 : div_cnt + 1'b1;

      if (done_o) data_q <= rx_sr;

      if (accept) begin
        cpha_q   <= cpha_i;
        lsb_q    <= lsb_first_i;
        hold_q   <= hold_cs_i;
        sck_o    <= cpol_i;
        cs_n_o   <= cs_pattern(cs_sel_i);
        edge_cnt <= '0;
        rx_sr    <= '0;
        // CPHA=0 must present the first bit before the first (sampling) edge.
        if (!cpha_i) begin
          sdo_o <= first_bit(data_i, lsb_first_i);
          tx_sr <= shift_out(data_i, lsb_first_i);
        end else begin
          tx_sr <= data_i;
        end
      end else if (state == XFER && tick) begin
        sck_o    <= ~sck_o;
        edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
        if (leading ^ cpha_q)
          rx_sr <= lsb_q ? {sdi_i, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], sdi_i};
        if (cpha_q ? leading : (!leading && !last_edge)) begin
          sdo_o <= first_bit(tx_sr, lsb_q);
          tx_sr <= shift_out(tx_sr, lsb_q);
        end
      end else if (done_o) begin
        if (!hold_q) cs_n_o <= '1;
      end else if (state == IDLE && cs_release_i) begin
        cs_n_o <= '1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master: directed scenarios plus
// randomized transfers against a bit-level SPI slave/reference model.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit, divide-by-2, two chip selects
  logic       start8 = 0, cpol8 = 0, cpha8 = 0, lsb8 = 0, hold8 = 0, rel8 = 0;
  logic [7:0] data8 = 0, dout8;
  logic [0:0] sel8 = 0;
  logic       busy8, done8, sck8, sdo8, sdi8;
  logic [1:0] cs8;
  logic       loop8 = 1, sdi_slave = 0;
  assign sdi8 = loop8 ? sdo8 : sdi_slave;

  spi_master #(.WIDTH(8), .CLK_DIV(2), .NUM_CS(2)) u8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .data_i(data8), .cs_sel_i(sel8),
    .cpol_i(cpol8), .cpha_i(cpha8), .lsb_first_i(lsb8), .hold_cs_i(hold8),
    .cs_release_i(rel8), .data_o(dout8), .busy_o(busy8), .done_o(done8),
    .sck_o(sck8), .sdo_o(sdo8), .sdi_i(sdi8), .cs_n_o(cs8)
  );

  // 16-bit, undivided, three chip selects, loopback
  logic        start16 = 0, cpol16 = 0, cpha16 = 0, lsb16 = 0, hold16 = 0, rel16 = 0;
  logic [15:0] data16 = 0, dout16;
  logic [1:0]  sel16 = 0;
  logic        busy16, done16, sck16, sdo16;
  logic [2:0]  cs16;

  spi_master #(.WIDTH(16), .CLK_DIV(1), .NUM_CS(3)) u16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .data_i(data16), .cs_sel_i(sel16),
    .cpol_i(cpol16), .cpha_i(cpha16), .lsb_first_i(lsb16), .hold_cs_i(hold16),
    .cs_release_i(rel16), .data_o(dout16), .busy_o(busy16), .done_o(done16),
    .sck_o(sck16), .sdo_o(sdo16), .sdi_i(sdo16), .cs_n_o(cs16)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of a word in transmission order.
  function automatic logic bitof(input logic [31:0] w, input int width, input logic lsb, input int i);
    logic [31:0] t;
    t = w >> (lsb ? i : width - 1 - i);
    return t[0];
  endfunction

  // Slave/monitor: counts SCK edges, serves slave_word, records sdi at sampling edges.
  logic [7:0] slave_word = 0;
  logic       slave_cpol = 0, slave_cpha = 0, slave_lsb = 0, samp_lvl = 1;
  int         lead_n = 0, trail_n = 0, done_cnt8 = 0, cs_gap = 0;
  logic       sck_prev = 0, busy_prev = 0, cs_watch = 0;
  logic       samp_q[$];

  always @(negedge clk) begin
    int idx;
    if ((busy8 || done8) && busy_prev && sck8 != sck_prev) begin
      if (sck8 == samp_lvl) samp_q.push_back(sdi8);
      if (sck8 != slave_cpol) lead_n++;
      else trail_n++;
    end
    idx = slave_cpha ? ((lead_n > 0) ? lead_n - 1 : 0) : trail_n;
    if (idx > 7) idx = 7;
    sdi_slave = bitof(32'(slave_word), 8, slave_lsb, idx);
    busy_prev = busy8;
    sck_prev  = sck8;
    if (done8) done_cnt8++;
    if (cs_watch && busy8 && cs8[0]) cs_gap++;
  end

  int a8 = 0;

  task automatic issue8(input logic [7:0] d, input logic s, input logic cpol, input logic cpha,
                        input logic lsb, input logic hold, input logic loop, input logic [7:0] sw);
    data8 = d; sel8 = s; cpol8 = cpol; cpha8 = cpha; lsb8 = lsb; hold8 = hold; loop8 = loop;
    slave_word = sw; slave_cpol = cpol; slave_cpha = cpha; slave_lsb = lsb;
    lead_n = 0; trail_n = 0;
    sdi_slave = bitof(32'(sw), 8, lsb, 0);
    samp_lvl = ~(cpol ^ cpha);
    samp_q.delete();
    start8 = 1;
    a8 = cyc;
    @(negedge clk);
    start8 = 0;
  endtask

  // Starts at the negedge of accept cycle A, returns at the negedge of the done cycle.
  task automatic run8(input logic [7:0] d, input logic s, input logic cpol, input logic cpha,
                      input logic lsb, input logic hold, input logic loop, input logic [7:0] sw,
                      input int poke);
    logic [7:0] expw, got, expv;
    int n;
    expw = loop ? d : sw;
    issue8(d, s, cpol, cpha, lsb, hold, loop, sw);
    chk("busy_a1", busy8, 1);
    chk("cs_a1", cs8, s ? 2'b01 : 2'b10);
    chk("sck_a1", sck8, cpol);
    if (!cpha) chk("sdo_first", sdo8, bitof(32'(d), 8, lsb, 0));
    n = 0;
    while (!done8 && n < 200) begin
      if (n == poke) begin data8 = 8'hFF; start8 = 1; end
      @(negedge clk);
      start8 = 0;
      n++;
    end
    chk("done_latency", cyc - a8, 36);
    chk("data_o", dout8, expw);
    chk("busy_at_done", busy8, 0);
    chk("nsamp", samp_q.size(), 8);
    got = 0; expv = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < samp_q.size()) got[i] = samp_q[i];
      expv[i] = bitof(32'(expw), 8, lsb, i);
    end
    chk("samples", got, expv);
  endtask

  task automatic after8(input logic s, input logic cpol, input logic hold);
    @(negedge clk);
    chk("cs_after", cs8, hold ? (s ? 2'b01 : 2'b10) : 2'b11);
    chk("sck_idle", sck8, cpol);
    chk("done_clear", done8, 0);
  endtask

  initial begin
    int dc, a16, n;
    logic [7:0] d, sw;
    logic cp, ch, lb, sl, lp;
    logic [15:0] w16;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_data", dout8, 0);
    chk("rst_sdo", sdo8, 0);
    chk("rst_sck", sck8, 0);
    chk("rst_cs", cs8, 2'b11);
    chk("rst_cs16", cs16, 3'b111);
    rst = 0;
    @(negedge clk);

    // Mode 0 loopback, CS1
    run8(8'hA5, 1'b1, 0, 0, 0, 0, 1, 8'h00, -1);
    after8(1'b1, 0, 0);

    // Mode 3 against slave returning 0x3C
    run8(8'h81, 1'b0, 1, 1, 0, 0, 0, 8'h3C, -1);
    after8(1'b0, 1, 0);

    // LSB-first 0x01: only the first sampled bit is one
    run8(8'h01, 1'b0, 0, 0, 1, 0, 1, 8'h00, -1);
    after8(1'b0, 0, 0);

    // Held-CS burst, second start in the done cycle, stray start mid-word
    repeat (2) @(negedge clk);
    dc = done_cnt8;
    cs_gap = 0;
    cs_watch = 1;
    run8(8'h12, 1'b0, 0, 0, 0, 1, 1, 8'h00, -1);
    run8(8'h34, 1'b0, 0, 0, 0, 0, 1, 8'h00, 10);
    after8(1'b0, 0, 0);
    cs_watch = 0;
    chk("burst_cs_gap", cs_gap, 0);
    repeat (60) @(negedge clk);
    chk("burst_done_pulses", done_cnt8 - dc, 2);

    // Reset during bit 4 of the XFER phase
    issue8(8'hC3, 1'b1, 1, 0, 0, 0, 1, 8'h00);
    repeat (18) @(negedge clk);
    chk("pre_rst_busy", busy8, 1);
    dc = done_cnt8;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_cs", cs8, 2'b11);
    chk("mid_rst_sck", sck8, 0);
    chk("mid_rst_done", done8, 0);
    rst = 0;
    repeat (50) @(negedge clk);
    chk("no_done_after_rst", done_cnt8 - dc, 0);
    run8(8'h5A, 1'b0, 0, 0, 0, 0, 1, 8'h00, -1);
    after8(1'b0, 0, 0);

    // Randomized transfers across modes, orders, selects and loopback/slave
    for (int k = 0; k < 10; k++) begin
      d  = 8'($urandom);
      sw = 8'($urandom);
      cp = 1'($urandom); ch = 1'($urandom); lb = 1'($urandom);
      sl = 1'($urandom); lp = 1'($urandom);
      run8(d, sl, cp, ch, lb, 0, lp, sw, -1);
      after8(sl, cp, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // 16-bit undivided: latency, held CS, release while idle
    data16 = 16'hBEEF; sel16 = 2'd1; hold16 = 1; start16 = 1;
    a16 = cyc;
    @(negedge clk);
    start16 = 0;
    chk("cs16_a1", cs16, 3'b101);
    n = 0;
    while (!done16 && n < 200) begin @(negedge clk); n++; end
    chk("done16_latency", cyc - a16, 34);
    chk("data16", dout16, 16'hBEEF);
    repeat (4) @(negedge clk);
    chk("cs16_held", cs16, 3'b101);
    chk("busy16_idle", busy16, 0);
    rel16 = 1;
    @(negedge clk);
    rel16 = 0;
    chk("cs16_release", cs16, 3'b111);

    // Out-of-range select: no CS asserts but the word still completes
    w16 = 16'($urandom);
    data16 = w16; sel16 = 2'd3; hold16 = 0; cpol16 = 1; cpha16 = 1; lsb16 = 1; start16 = 1;
    a16 = cyc;
    @(negedge clk);
    start16 = 0;
    chk("cs16_oor", cs16, 3'b111);
    chk("busy16_oor", busy16, 1);
    n = 0;
    while (!done16 && n < 200) begin @(negedge clk); n++; end
    chk("done16_oor_latency", cyc - a16, 34);
    chk("data16_oor", dout16, w16);
    @(negedge clk);
    chk("sck16_idle", sck16, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
